// File: rtl/empty_ptr_pool.sv
// Free-address pool for the hash-table data RAM: lazy fresh counter,
// recycle FIFO, show-ahead output register and optional allocation bitmap.
module empty_ptr_pool #(
  parameter int A_WIDTH   = 4,
  parameter int DEPTH     = 2**A_WIDTH,
  parameter int FIRST_PTR = 1,
  parameter bit CHECK_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [A_WIDTH-1:0] add_empty_ptr,
  input  logic               add_empty_ptr_en,
  input  logic               next_empty_ptr_rd_ack,
  output logic [A_WIDTH-1:0] next_empty_ptr,
  output logic               next_empty_ptr_val,
  output logic [A_WIDTH:0]   free_cnt,
  output logic               err_double_free,
  output logic               err_range,
  output logic               err_underflow
);

  localparam int CW = A_WIDTH + 1;
  localparam int FD = DEPTH - FIRST_PTR;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FIRST_C = CW'(FIRST_PTR);
  localparam logic [CW-1:0] FD_C    = CW'(FD);
  localparam logic [CW-1:0] INIT_C  = CW'(DEPTH - FIRST_PTR);
  localparam logic [PW-1:0] LAST_P  = PW'(FD - 1);

  logic [A_WIDTH-1:0]   fifo_mem [FD];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic [CW-1:0]        fresh;
  logic [2**A_WIDTH-1:0] bmap;

  logic [CW-1:0] add_w;
  logic ack_ok;
  logic in_range;
  logic allocated;
  logic fifo_full;
  logic push;
  logic pop;
  logic need;
  logic from_fresh;

  assign add_w     = {1'b0, add_empty_ptr};
  assign ack_ok    = next_empty_ptr_rd_ack & next_empty_ptr_val;
  assign in_range  = (add_w >= FIRST_C) && (add_w < DEPTH_C);
  // an address acked this cycle counts as allocated for a same-cycle release
  assign allocated = !CHECK_EN || bmap[add_empty_ptr] ||
                     (ack_ok && (next_empty_ptr == add_empty_ptr));
  assign fifo_full = (fifo_cnt == FD_C);
  assign push      = add_empty_ptr_en & in_range & allocated & ~fifo_full;
  assign need      = ~next_empty_ptr_val | ack_ok;
  assign pop       = need & (fifo_cnt != '0);
  assign from_fresh = need & ~pop & (fresh < DEPTH_C);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= add_empty_ptr;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_cnt           <= '0;
      fresh              <= FIRST_C;
      next_empty_ptr     <= '0;
      next_empty_ptr_val <= 1'b0;
      free_cnt           <= INIT_C;
      err_double_free    <= 1'b0;
      err_range          <= 1'b0;
      err_underflow      <= 1'b0;
    end else begin
      err_underflow   <= next_empty_ptr_rd_ack & ~next_empty_ptr_val;
      err_range       <= add_empty_ptr_en & ~in_range;
      err_double_free <= add_empty_ptr_en & in_range &
                         (~allocated | fifo_full);
      if (push)
        wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      case ({push, ack_ok})
        2'b10:   free_cnt <= free_cnt + 1'b1;
        2'b01:   free_cnt <= free_cnt - 1'b1;
        default: ;
      endcase
      if (pop) begin
        next_empty_ptr     <= fifo_mem[rd_ptr];
        next_empty_ptr_val <= 1'b1;
      end else if (from_fresh) begin
        next_empty_ptr     <= fresh[A_WIDTH-1:0];
        next_empty_ptr_val <= 1'b1;
        fresh              <= fresh + 1'b1;
      end else if (need) begin
        next_empty_ptr_val <= 1'b0;
      end
    end
  end

  generate
    if (CHECK_EN) begin : g_bmap
      always_ff @(posedge clk) begin
        if (srst) begin
          bmap <= '0;
        end else begin
          if (ack_ok) bmap[next_empty_ptr] <= 1'b1;
          if (push)   bmap[add_empty_ptr]  <= 1'b0;
        end
      end
    end else begin : g_nobmap
      assign bmap = '0;
    end
  endgenerate

endmodule

// File: tb/tb_empty_ptr_pool.sv
// Bench for empty_ptr_pool: queue-based pool model checked every cycle,
// plus directed sequences with literal expectations.
module tb_empty_ptr_pool;

  localparam int AW = 5;
  localparam int DP = 16;
  localparam int FP = 1;

  logic          clk = 1'b0;
  logic          srst;
  logic [AW-1:0] add_ptr;
  logic          add_en;
  logic          ack;
  logic [AW-1:0] nptr;
  logic          nval;
  logic [AW:0]   fcnt;
  logic          e_df_d;
  logic          e_rng_d;
  logic          e_und_d;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  empty_ptr_pool #(
    .A_WIDTH(AW), .DEPTH(DP), .FIRST_PTR(FP), .CHECK_EN(1'b1)
  ) dut (
    .clk(clk),
    .srst(srst),
    .add_empty_ptr(add_ptr),
    .add_empty_ptr_en(add_en),
    .next_empty_ptr_rd_ack(ack),
    .next_empty_ptr(nptr),
    .next_empty_ptr_val(nval),
    .free_cnt(fcnt),
    .err_double_free(e_df_d),
    .err_range(e_rng_d),
    .err_underflow(e_und_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // pool model: free addresses are a queue of recycled ones followed by
  // the untouched range [fresh, DP); alloc[] marks addresses held by users
  int q[$];
  int fresh;
  bit m_val;
  int m_ptr;
  bit alloc[DP];
  int m_free;
  bit m_df, m_rng, m_und;
  bit m_ack_ok, m_acc;
  int m_ap;

  always @(posedge clk) begin
    if (srst) begin
      q.delete();
      fresh = FP;
      m_val = 0;
      m_ptr = 0;
      foreach (alloc[i]) alloc[i] = 0;
      m_free = DP - FP;
      m_df = 0; m_rng = 0; m_und = 0;
    end else begin
      m_ack_ok = ack && m_val;
      m_und = ack && !m_val;
      m_rng = 0; m_df = 0; m_acc = 0;
      if (m_ack_ok) alloc[m_ptr] = 1;
      if (!m_val || m_ack_ok) begin
        if (q.size() > 0) begin
          m_ptr = q.pop_front();
          m_val = 1;
        end else if (fresh < DP) begin
          m_ptr = fresh;
          fresh = fresh + 1;
          m_val = 1;
        end else begin
          m_val = 0;
        end
      end
      if (add_en) begin
        m_ap = int'(add_ptr);
        if (m_ap < FP || m_ap >= DP) m_rng = 1;
        else if (!alloc[m_ap]) m_df = 1;
        else begin
          alloc[m_ap] = 0;
          q.push_back(m_ap);
          m_acc = 1;
        end
      end
      m_free = m_free + int'(m_acc) - int'(m_ack_ok);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("val", nval, m_val);
      if (m_val) chk("ptr", nptr, m_ptr);
      chk("free_cnt", fcnt, m_free);
      chk("err_double_free", e_df_d, m_df);
      chk("err_range", e_rng_d, m_rng);
      chk("err_underflow", e_und_d, m_und);
    end
  end

  task automatic cyc(input logic r, input logic en, input int p,
                     input logic a);
    srst    = r;
    add_en  = en;
    add_ptr = AW'(p);
    ack     = a;
    @(negedge clk);
  endtask

  initial begin
    srst = 1'b1; add_en = 1'b0; add_ptr = '0; ack = 1'b0;
    @(negedge clk);
    chk_en = 1;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 3, 1);
    chk("lit_rst_val", nval, 0);
    chk("lit_rst_free", fcnt, 15);
    chk("lit_rst_ptr", nptr, 0);

    // drain the whole pool with back-to-back acks
    cyc(0, 0, 0, 0);
    chk("lit_first_val", nval, 1);
    for (int k = 1; k <= 15; k++) begin
      chk("lit_seq_ptr", nptr, k);
      cyc(0, 0, 0, 1);
    end
    chk("lit_exh_val", nval, 0);
    chk("lit_exh_free", fcnt, 0);

    // range errors and underflow on an exhausted pool
    cyc(0, 1, 0, 0);
    chk("lit_rng0", e_rng_d, 1);
    cyc(0, 1, 16, 0);
    chk("lit_rng16", e_rng_d, 1);
    cyc(0, 0, 0, 1);
    chk("lit_und", e_und_d, 1);
    chk("lit_und_free", fcnt, 0);

    // release into empty pool: t+1 count, t+2 output
    cyc(0, 1, 7, 0);
    chk("lit_rel_free", fcnt, 1);
    chk("lit_rel_val_t1", nval, 0);
    cyc(0, 0, 0, 0);
    chk("lit_rel_val_t2", nval, 1);
    chk("lit_rel_ptr", nptr, 7);

    // recycled addresses take priority over fresh ones
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 2, 0);
    cyc(0, 1, 3, 0);
    chk("lit_prio_held", nptr, 4);
    cyc(0, 0, 0, 1);
    chk("lit_prio_2", nptr, 2);
    cyc(0, 0, 0, 1);
    chk("lit_prio_3", nptr, 3);
    cyc(0, 0, 0, 1);
    chk("lit_prio_5", nptr, 5);
    chk("lit_prio_free", fcnt, 11);

    // double free
    cyc(0, 0, 0, 1);
    cyc(0, 1, 5, 0);
    chk("lit_df_first", e_df_d, 0);
    chk("lit_df_free1", fcnt, 11);
    cyc(0, 1, 5, 0);
    chk("lit_df_second", e_df_d, 1);
    chk("lit_df_free2", fcnt, 11);

    // same-cycle ack and release of the held address
    cyc(0, 1, 6, 1);
    chk("lit_same_df", e_df_d, 0);
    chk("lit_same_free", fcnt, 11);
    chk("lit_same_ptr", nptr, 5);
    cyc(0, 0, 0, 1);
    chk("lit_same_back", nptr, 6);

    // mid-stream reset discards FIFO and fresh progress
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);
    cyc(0, 1, 3, 0);
    cyc(0, 1, 6, 0);
    chk("lit_mid_free", fcnt, 9);
    cyc(1, 0, 0, 0);
    chk("lit_mid_rst_free", fcnt, 15);
    chk("lit_mid_rst_val", nval, 0);
    cyc(0, 0, 0, 0);
    chk("lit_mid_ptr1", nptr, 1);
    cyc(0, 0, 0, 1);
    chk("lit_mid_ptr2", nptr, 2);
    cyc(0, 0, 0, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
